// File: rtl/imm_gen_core.sv
// RV32I immediate generator: decodes the opcode, sign-extends the immediate and
// registers it with a one-cycle latency. Define IMM_GEN_UTYPE_EN to decode LUI/AUIPC.
module imm_gen_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic [31:0] imm_out,
    output logic        imm_valid,
    output logic [2:0]  imm_fmt
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned FMT_W = 3;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

    logic [OPC_W-1:0] opcode_c;
    logic             sign_c;
    logic [XLEN-1:0]  imm_c;
    logic [FMT_W-1:0] fmt_c;

    assign opcode_c = instruction[OPC_W-1:0];
    assign sign_c   = instruction[31];

    // Opcode-only decode; funct3/funct7 never influence the immediate.
    always_comb begin
        imm_c = '0;
        fmt_c = FMT_NONE;
        unique case (opcode_c)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt_c = FMT_I;
                imm_c = {{20{sign_c}}, instruction[31:20]};
            end
            OPC_STORE: begin
                fmt_c = FMT_S;
                imm_c = {{20{sign_c}}, instruction[31:25], instruction[11:7]};
            end
            OPC_BRANCH: begin
                fmt_c = FMT_B;
                imm_c = {{19{sign_c}}, sign_c, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
            end
            OPC_JAL: begin
                fmt_c = FMT_J;
                imm_c = {{11{sign_c}}, sign_c, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
            end
`ifdef IMM_GEN_UTYPE_EN
            OPC_LUI, OPC_AUIPC: begin
                fmt_c = FMT_U;
                imm_c = {instruction[31:12], 12'h000};
            end
`endif
            default: begin
                fmt_c = FMT_NONE;
                imm_c = '0;
            end
        endcase
    end

    // Result register: payload holds when idle, valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_out   <= '0;
            imm_fmt   <= FMT_NONE;
            imm_valid <= 1'b0;
        end else begin
            imm_valid <= instr_valid;
            if (instr_valid) begin
                imm_out <= imm_c;
                imm_fmt <= fmt_c;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_core.sv
// Directed bench for imm_gen_core: an arithmetic reference model checked every cycle,
// plus literal expectations on the documented example words.
module tb_imm_gen_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] imm_out;
    logic        imm_valid;
    logic [2:0]  imm_fmt;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .imm_out    (imm_out),
        .imm_valid  (imm_valid),
        .imm_fmt    (imm_fmt)
    );

    always #5 clk = ~clk;

    // Reference decode built from field arithmetic on the signed word.
    function automatic void ref_decode(input logic [31:0] ins, output int imm, output int fmt);
        int s;
        s = $signed(ins);
        imm = 0;
        fmt = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin fmt = 1; imm = s >>> 20; end
            7'h23: begin fmt = 2; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin
                fmt = 3;
                imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                    + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                fmt = 5;
                imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                    + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
`ifdef IMM_GEN_UTYPE_EN
            7'h37, 7'h17: begin fmt = 4; imm = int'(ins & 32'hFFFFF000); end
`endif
            default: begin fmt = 0; imm = 0; end
        endcase
    endfunction

    // Model state, advanced on the same edge the DUT samples.
    logic        known = 1'b0;
    logic [31:0] exp_out;
    logic [2:0]  exp_fmt;
    logic        exp_valid;

    always @(posedge clk) begin
        int mi, mf;
        if (rst_n === 1'b0) begin
            known     <= 1'b1;
            exp_out   <= 32'h0;
            exp_fmt   <= 3'd0;
            exp_valid <= 1'b0;
        end else if (known) begin
            exp_valid <= instr_valid;
            if (instr_valid) begin
                ref_decode(instruction, mi, mf);
                exp_out <= 32'(mi);
                exp_fmt <= 3'(mf);
            end
        end
    end

    // Continuous comparison against the model once it is anchored by reset.
    always @(negedge clk) begin
        if (known) begin
            n_tests++;
            if (imm_out !== exp_out || imm_fmt !== exp_fmt || imm_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL model t=%0t: got out=%h fmt=%0d v=%b, want out=%h fmt=%0d v=%b",
                         $time, imm_out, imm_fmt, imm_valid, exp_out, exp_fmt, exp_valid);
            end
        end
    end

    // Apply inputs at a falling edge and return at the falling edge after capture.
    task automatic cyc(input logic r, input logic v, input logic [31:0] ins);
        rst_n       = r;
        instr_valid = v;
        instruction = ins;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] o, input logic [2:0] f,
                       input logic vv);
        n_tests++;
        if (imm_out !== o || imm_fmt !== f || imm_valid !== vv) begin
            n_fail++;
            $display("FAIL %s: got out=%h fmt=%0d v=%b, want out=%h fmt=%0d v=%b",
                     name, imm_out, imm_fmt, imm_valid, o, f, vv);
        end
    endtask

    task automatic chk_model(input string name, input logic [31:0] ins,
                             input logic [31:0] o, input int f);
        int mi, mf;
        ref_decode(ins, mi, mf);
        n_tests++;
        if (32'(mi) !== o || mf != f) begin
            n_fail++;
            $display("FAIL %s: model out=%h fmt=%0d, want out=%h fmt=%0d", name, 32'(mi), mf, o, f);
        end
    endtask

    initial begin
        logic [31:0] prev;
        rst_n = 1'b0; instr_valid = 1'b1; instruction = 32'hF1230493;
        @(negedge clk);

        // Pin the model on hand-derived values.
        chk_model("model_i", 32'hF1230493, 32'hFFFFFF12, 1);
        chk_model("model_b", 32'hFE0426E3, 32'hFFFFFFEC, 3);
        chk_model("model_j", 32'h004000EF, 32'h00000004, 5);
        chk_model("model_s_neg", 32'hFE112C23, 32'hFFFFFFF8, 2);

        cyc(1'b0, 1'b1, 32'h00512223);
        cyc(1'b0, 1'b1, 32'hFFFFFFFF);
        chk("reset_overrides_valid", 32'h0, 3'd0, 1'b0);

        cyc(1'b1, 1'b1, 32'hF1230493); chk("addi_neg",  32'hFFFFFF12, 3'd1, 1'b1);
        cyc(1'b1, 1'b1, 32'h00412083); chk("load",      32'h00000004, 3'd1, 1'b1);
        cyc(1'b1, 1'b1, 32'h00512223); chk("store",     32'h00000004, 3'd2, 1'b1);
        cyc(1'b1, 1'b1, 32'hFE0426E3); chk("branch",    32'hFFFFFFEC, 3'd3, 1'b1);
        cyc(1'b1, 1'b1, 32'h004000EF); chk("jal",       32'h00000004, 3'd5, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFF00067); chk("jalr_m1",   32'hFFFFFFFF, 3'd1, 1'b1);
        cyc(1'b1, 1'b1, 32'h40315093); chk("srai_full", 32'h00000403, 3'd1, 1'b1);
        cyc(1'b1, 1'b1, 32'h80000063); chk("branch_min", 32'hFFFFF000, 3'd3, 1'b1);
        cyc(1'b1, 1'b1, 32'h800000EF); chk("jal_min",   32'hFFF00000, 3'd5, 1'b1);
        cyc(1'b1, 1'b1, 32'h00000000); chk("zero_word", 32'h00000000, 3'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'hF1230493);
        cyc(1'b1, 1'b0, 32'h00412083); chk("hold",      32'hFFFFFF12, 3'd1, 1'b0);
        cyc(1'b1, 1'b0, 32'h004000EF); chk("hold2",     32'hFFFFFF12, 3'd1, 1'b0);

`ifdef IMM_GEN_UTYPE_EN
        cyc(1'b1, 1'b1, 32'h123450B7); chk("lui",   32'h12345000, 3'd4, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFFFF097); chk("auipc", 32'hFFFFF000, 3'd4, 1'b1);
`else
        cyc(1'b1, 1'b1, 32'h123450B7); chk("lui_off",   32'h00000000, 3'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFFFF097); chk("auipc_off", 32'h00000000, 3'd0, 1'b1);
`endif

        // Varied patterns checked only by the model process.
        for (int i = 0; i < 40; i++) begin
            prev = $urandom;
            case (i % 8)
                0: prev[6:0] = 7'h13;
                1: prev[6:0] = 7'h03;
                2: prev[6:0] = 7'h23;
                3: prev[6:0] = 7'h63;
                4: prev[6:0] = 7'h6F;
                5: prev[6:0] = 7'h37;
                6: prev[6:0] = 7'h67;
                default: ;
            endcase
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), prev);
        end

        cyc(1'b1, 1'b1, 32'hFE0426E3); chk("branch_again", 32'hFFFFFFEC, 3'd3, 1'b1);
        cyc(1'b0, 1'b1, 32'h004000EF); chk("reset_after_load", 32'h0, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h004000EF); chk("first_after_reset", 32'h00000004, 3'd5, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);        chk("idle_end", 32'h00000004, 3'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_core.md
IMM_GEN_CORE -- requirements
Module: imm_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst_n SHALL be: input, 1 bit, synchronous active-low reset, sampled on rising clk.
REQ-004 Port instruction SHALL be: input, 32 bits, RV32I instruction word to decode.
REQ-005 Port instr_valid SHALL be: input, 1 bit, qualifies instruction in the current cycle.
REQ-006 Port imm_out SHALL be: output, 32 bits, registered sign-extended immediate.
REQ-007 Port imm_valid SHALL be: output, 1 bit, registered; high when imm_out holds a result captured the previous cycle.
REQ-008 Port imm_fmt SHALL be: output, 3 bits, registered format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; codes 6 and 7 are unused.

Function
REQ-009 Decode SHALL use opcode instruction[6:0] only; funct3 and funct7 are ignored.
REQ-010 Opcodes 0010011 (OP-IMM), 0000011 (LOAD) and 1100111 (JALR) SHALL select I format.
- Immediate = sign-extend instruction[31:20].
- Shift-immediates use the same full sign-extended field.
REQ-011 Opcode 0100011 (STORE) SHALL select S format.
- Immediate = sign-extend {instruction[31:25], instruction[11:7]}.
REQ-012 Opcode 1100011 (BRANCH) SHALL select B format.
- Immediate = sign-extend {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
REQ-013 Opcode 1101111 (JAL) SHALL select J format.
- Immediate = sign-extend {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
REQ-014 Sign extension SHALL always replicate instruction[31] into all upper bits.
REQ-015 Any other opcode SHALL select NONE format with immediate 32'h00000000.
- This includes all-zero words and U-type opcodes when the Configuration feature is disabled.
REQ-016 Latency SHALL be exactly one cycle.
- On a rising clk with rst_n=1 and instr_valid=1, imm_out and imm_fmt load the decode of instruction, and imm_valid is set to 1.
REQ-017 On a rising clk with rst_n=1 and instr_valid=0:
- imm_out and imm_fmt SHALL hold their previous values.
- imm_valid SHALL clear to 0.
REQ-018 There SHALL be no combinational path from inputs to outputs, and no further internal state.

Reset
REQ-019 On a rising clk with rst_n=0, imm_out SHALL become 0, imm_fmt SHALL become 0 (NONE) and imm_valid SHALL become 0.
- Reset overrides instr_valid.
REQ-020 Reset SHALL have no asynchronous effect; outputs change only on clk edges.
REQ-021 In the first cycle after rst_n returns high, a valid instruction SHALL be captured normally.

Configuration
REQ-022 Macro IMM_GEN_UTYPE_EN defined: opcodes 0110111 (LUI) and 0010111 (AUIPC) SHALL select U format.
- Immediate = {instruction[31:12], 12'h000}.
REQ-023 Macro IMM_GEN_UTYPE_EN undefined: those opcodes SHALL decode as NONE, with immediate 0 and fmt 0.

Verification
REQ-024 rst_n=0 for 2 cycles with instr_valid=1 and any instruction -> imm_out=00000000, imm_fmt=0, imm_valid=0.
REQ-025 Directed valid instructions, one per cycle, with outputs checked the next cycle:
- 32'hF1230493 -> FFFFFF12, fmt 1.
- 32'h00412083 -> 00000004, fmt 1.
- 32'h00512223 -> 00000004, fmt 2.
REQ-026 Branch and jump decodes, valid, next cycle:
- 32'hFE0426E3 -> FFFFFFEC (-20), fmt 3.
- 32'h004000EF -> 00000004, fmt 5.
REQ-027 32'h00000000 with instr_valid=1 -> imm_out=00000000, fmt 0, imm_valid=1.
- Then instr_valid=0 -> imm_valid=0 and imm_out unchanged.
REQ-028 32'h123450B7 (LUI) -> 12345000, fmt 4 when IMM_GEN_UTYPE_EN is defined; 00000000, fmt 0 when it is undefined.
REQ-029 Assert rst_n=0 in the cycle after loading 32'hFE0426E3 -> outputs return to reset values at that edge.
